network_pkt_read_control: RTL and testbench



---
 rtl/network_tx_pkg.sv | 43 ++++
 rtl/pkt_rd_valid_pipe.sv | 37 +++
 rtl/network_pkt_read_control.sv | 171 +++++++++++++++++
 tb/tb_network_pkt_read_control.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_tx_pkg.sv
// Shared line format, flag encodings and FSM state type for the per-port transmit read path.
package network_tx_pkg;

  localparam int LINE_W      = 134;
  localparam int FLAG_LO     = 132;
  localparam int INV_LO      = 128;
  localparam int INV_W       = 4;
  localparam int TAG_LO      = 80;
  localparam int TAG_W       = 48;
  localparam int BUFID_W     = 9;
  localparam int DEF_LINE_AW = 7;

  localparam logic [1:0] FLAG_MID    = 2'b00;
  localparam logic [1:0] FLAG_HEAD   = 2'b01;
  localparam logic [1:0] FLAG_TAIL   = 2'b10;
  localparam logic [1:0] FLAG_SINGLE = 2'b11;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } prc_state_e;

  function automatic logic flag_is_tail(input logic [1:0] f);
    return (f != FLAG_MID) && (f != FLAG_HEAD);
  endfunction

  function automatic logic flag_is_head(input logic [1:0] f);
    return (f == FLAG_HEAD) || (f == FLAG_SINGLE);
  endfunction

  function automatic line_t insert_tag(input line_t ln, input tag_t tag);
    line_t r;
    r = ln;
    r[TAG_LO +: TAG_W] = tag;
    return r;
  endfunction

endpackage

// File: rtl/pkt_rd_valid_pipe.sv
// Tracks outstanding packet-buffer reads: a LAT-deep valid/line-index shift register
// that flags when each read's data returns and whether any read is still in flight.
module pkt_rd_valid_pipe #(
  parameter int LAT     = 2,
  parameter int LINE_AW = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               vld_i,
  input  logic [LINE_AW-1:0] line_i,
  output logic               ret_vld_o,
  output logic [LINE_AW-1:0] ret_line_o,
  output logic               empty_o
);

  logic [LAT-1:0]              vld_q;
  logic [LAT-1:0][LINE_AW-1:0] line_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      line_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      line_q[0] <= line_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign ret_vld_o  = vld_q[LAT-1];
  assign ret_line_o = line_q[LAT-1];
  assign empty_o    = ~|vld_q;

endmodule

// File: rtl/network_pkt_read_control.sv
// Reads one scheduled packet out of the buffer into the TX FIFO, releases its bufid, then acks
// the scheduler. Define TSNTAG_RESTORE_EN to overwrite head-line bits [127:80] with the TSNtag.
module network_pkt_read_control
  import network_tx_pkg::*;
#(
  parameter int RAM_RD_LAT = 2,
  parameter int LINE_AW    = DEF_LINE_AW
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [BUFID_W-1:0]         iv_pkt_bufid,
  input  logic [TAG_W-1:0]           iv_tsntag,
  input  logic                       i_pkt_bufid_wr,
  output logic                       o_pkt_bufid_ack,
  output logic [BUFID_W+LINE_AW-1:0] ov_pkt_raddr,
  output logic                       o_pkt_rd,
  input  logic [LINE_W-1:0]          iv_pkt_data,
  input  logic                       i_tx_fifo_afull,
  output logic [LINE_W-1:0]          ov_data,
  output logic                       o_data_wr,
  output logic [BUFID_W-1:0]         ov_release_bufid,
  output logic                       o_release_wr,
  output logic [15:0]                ov_err_cnt,
  output logic [1:0]                 ov_prc_state
);

  localparam logic [LINE_AW-1:0] LAST_LINE = {LINE_AW{1'b1}};

  prc_state_e         state_q;
  logic [BUFID_W-1:0] bufid_q;
  logic [LINE_AW-1:0] line_q;
  logic               tail_seen_q;
  line_t              data_q;
  logic               data_wr_q;
  logic               ack_q;
  logic               rel_wr_q;
  logic [BUFID_W-1:0] rel_bufid_q;
  logic [15:0]        err_cnt_q;

  logic               ret_vld;
  logic [LINE_AW-1:0] ret_line;
  logic               pipe_empty;
  logic [1:0]         ret_flag;
  logic               fwd;
  logic               last_ret;
  logic               force_tail;
  logic               ret_tail;
  logic               rd;
  line_t              fwd_line;

  pkt_rd_valid_pipe #(
    .LAT     (RAM_RD_LAT),
    .LINE_AW (LINE_AW)
  ) u_pipe (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .vld_i      (rd),
    .line_i     (line_q),
    .ret_vld_o  (ret_vld),
    .ret_line_o (ret_line),
    .empty_o    (pipe_empty)
  );

`ifdef TSNTAG_RESTORE_EN
  tag_t tsntag_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tsntag_q <= '0;
    end else if (state_q == ST_IDLE && i_pkt_bufid_wr) begin
      tsntag_q <= iv_tsntag;
    end
  end
`else
  logic unused_tsntag;
  assign unused_tsntag = ^iv_tsntag;
`endif

  // A returning tail also blocks issue in the same cycle, so no read is wasted past it.
  always_comb begin
    ret_flag   = iv_pkt_data[FLAG_LO +: 2];
    fwd        = ret_vld && !tail_seen_q;
    last_ret   = (ret_line == LAST_LINE);
    force_tail = fwd && last_ret && !flag_is_tail(ret_flag);
    ret_tail   = fwd && (flag_is_tail(ret_flag) || last_ret);
    rd         = (state_q == ST_READ) && !i_tx_fifo_afull && !tail_seen_q && !ret_tail;
    fwd_line   = iv_pkt_data;
`ifdef TSNTAG_RESTORE_EN
    if (flag_is_head(ret_flag)) begin
      fwd_line = insert_tag(fwd_line, tsntag_q);
    end
`endif
    if (force_tail) begin
      fwd_line[FLAG_LO +: 2]    = FLAG_TAIL;
      fwd_line[INV_LO +: INV_W] = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      bufid_q     <= '0;
      line_q      <= '0;
      tail_seen_q <= 1'b0;
      data_q      <= '0;
      data_wr_q   <= 1'b0;
      ack_q       <= 1'b0;
      rel_wr_q    <= 1'b0;
      rel_bufid_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      data_wr_q <= fwd;
      ack_q     <= 1'b0;
      rel_wr_q  <= 1'b0;
      if (fwd) begin
        data_q <= fwd_line;
      end
      if (ret_tail) begin
        tail_seen_q <= 1'b1;
      end
      if (force_tail && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (i_pkt_bufid_wr) begin
            bufid_q     <= iv_pkt_bufid;
            line_q      <= '0;
            tail_seen_q <= 1'b0;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          // The line counter parks at the last line instead of wrapping.
          if (rd) begin
            if (line_q == LAST_LINE) begin
              state_q <= ST_DRAIN;
            end else begin
              line_q <= line_q + LINE_AW'(1);
            end
          end
          if (ret_tail || tail_seen_q) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state_q     <= ST_DONE;
            ack_q       <= 1'b1;
            rel_wr_q    <= 1'b1;
            rel_bufid_q <= bufid_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pkt_rd         = rd;
  assign ov_pkt_raddr     = rd ? {bufid_q, line_q} : '0;
  assign ov_data          = data_q;
  assign o_data_wr        = data_wr_q;
  assign o_pkt_bufid_ack  = ack_q;
  assign o_release_wr     = rel_wr_q;
  assign ov_release_bufid = rel_bufid_q;
  assign ov_err_cnt       = err_cnt_q;
  assign ov_prc_state     = state_q;

endmodule

// File: tb/tb_network_pkt_read_control.sv
// Directed bench for network_pkt_read_control with a packet-level reference model and RAM model.
module tb_network_pkt_read_control;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [8:0]   iv_pkt_bufid;
  logic [47:0]  iv_tsntag;
  logic         i_pkt_bufid_wr;
  logic         o_pkt_bufid_ack;
  logic [11:0]  ov_pkt_raddr;
  logic         o_pkt_rd;
  logic [133:0] iv_pkt_data;
  logic         i_tx_fifo_afull;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [8:0]   ov_release_bufid;
  logic         o_release_wr;
  logic [15:0]  ov_err_cnt;
  logic [1:0]   ov_prc_state;

  network_pkt_read_control #(.RAM_RD_LAT(2), .LINE_AW(3)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .iv_pkt_bufid     (iv_pkt_bufid),
    .iv_tsntag        (iv_tsntag),
    .i_pkt_bufid_wr   (i_pkt_bufid_wr),
    .o_pkt_bufid_ack  (o_pkt_bufid_ack),
    .ov_pkt_raddr     (ov_pkt_raddr),
    .o_pkt_rd         (o_pkt_rd),
    .iv_pkt_data      (iv_pkt_data),
    .i_tx_fifo_afull  (i_tx_fifo_afull),
    .ov_data          (ov_data),
    .o_data_wr        (o_data_wr),
    .ov_release_bufid (ov_release_bufid),
    .o_release_wr     (o_release_wr),
    .ov_err_cnt       (ov_err_cnt),
    .ov_prc_state     (ov_prc_state)
  );

  initial forever #4 i_clk = ~i_clk;

  // Packet buffer: 512 bufids x 8 lines, two-cycle read latency.
  logic [133:0] mem [0:511][0:7];
  logic [11:0]  r1 = '0;
  logic [11:0]  r2 = '0;
  always @(posedge i_clk) begin
    r1 <= ov_pkt_raddr;
    r2 <= r1;
  end
  assign iv_pkt_data = mem[r2[11:3]][r2[2:0]];

  typedef struct {
    logic [8:0]  bufid;
    logic [15:0] err;
  } rel_t;

  logic [133:0] exp_q[$];
  rel_t         rel_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           err_model = 0;
  int           rd_n, wr_n, ack_n, acc_n;
  int           first_rd_cyc, first_wr_cyc, last_wr_cyc, ack_cyc, t0;
  bit           rd_active;
  logic [8:0]   rd_bufid;
  logic [2:0]   rd_line;
  logic [133:0] head_dat, last_dat;
  logic [8:0]   last_rel;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the packet model.
  always @(negedge i_clk) begin
    if (o_pkt_rd) begin
      rd_n++;
      if (rd_n == 1) first_rd_cyc = cyc;
      chk("rd_addr", {i_tx_fifo_afull, rd_active, ov_pkt_raddr}, {1'b0, 1'b1, rd_bufid, rd_line});
      rd_line = rd_line + 3'd1;
    end
    if (o_data_wr) begin
      wr_n++;
      if (wr_n == 1) begin
        first_wr_cyc = cyc;
        head_dat = ov_data;
      end
      last_wr_cyc = cyc;
      last_dat = ov_data;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL data_unexpected: got %h expected no write", ov_data);
      end else begin
        chk("data", ov_data, exp_q.pop_front());
      end
    end
    if (o_pkt_bufid_ack || o_release_wr) begin
      rel_t e;
      ack_n++;
      ack_cyc = cyc;
      last_rel = ov_release_bufid;
      rd_active = 0;
      if (rel_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL release_unexpected: got bufid %h expected none", ov_release_bufid);
      end else begin
        e = rel_q.pop_front();
        chk("release", {o_pkt_bufid_ack, o_release_wr, ov_release_bufid, ov_err_cnt},
            {1'b1, 1'b1, e.bufid, e.err});
      end
    end
  end

  function automatic logic [133:0] rnd_line();
    return {2'b00, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic fill(input logic [8:0] b);
    for (int l = 0; l < 8; l++) mem[b][l] = rnd_line();
  endtask

  task automatic build(input logic [8:0] b, input logic [47:0] tag);
    logic [133:0] ln;
    logic [1:0]   f;
    logic [47:0]  hdr_tag;
    for (int l = 0; l < 8; l++) begin
      ln = mem[b][l];
      f = ln[133:132];
      hdr_tag = tag;
`ifndef TSNTAG_RESTORE_EN
      hdr_tag = ln[127:80];
`endif
      if (f[0]) ln[127:80] = hdr_tag;
      if (l == 7 && !f[1]) begin
        ln[133:132] = 2'b10;
        ln[131:128] = 4'd0;
        if (err_model < 65535) err_model++;
      end
      exp_q.push_back(ln);
      if (f[1] || l == 7) break;
    end
    rel_q.push_back('{b, 16'(err_model)});
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [8:0] b, input logic [47:0] tag, input bit accepted);
    iv_pkt_bufid = b;
    iv_tsntag = tag;
    i_pkt_bufid_wr = 1'b1;
    if (accepted) begin
      rd_n = 0;
      wr_n = 0;
      rd_active = 1;
      rd_bufid = b;
      rd_line = 3'd0;
      t0 = cyc;
      acc_n++;
      build(b, tag);
    end
    tick();
    i_pkt_bufid_wr = 1'b0;
  endtask

  task automatic wait_ack(input int start);
    for (int i = 0; i < 200 && ack_n == start; i++) tick();
    if (ack_n == start) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", ack_n, start + 1);
    end
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {o_pkt_rd, ov_pkt_raddr, o_data_wr, o_pkt_bufid_ack, o_release_wr,
             ov_release_bufid, ov_err_cnt, ov_prc_state}, '0);
    chk({nm, "_data"}, ov_data, '0);
  endtask

  initial begin
    int a0;
    rd_n = 0; wr_n = 0; ack_n = 0; acc_n = 0; rd_active = 0;
    rd_bufid = '0; rd_line = '0;
    first_rd_cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0; ack_cyc = 0; t0 = 0;
    i_rst = 1'b1;
    iv_pkt_bufid = '0;
    iv_tsntag = '0;
    i_pkt_bufid_wr = 1'b0;
    i_tx_fifo_afull = 1'b0;

    fill(9'h005); mem[9'h005][0][133:128] = {2'b11, 4'd7};
    fill(9'h01A); mem[9'h01A][0][133:132] = 2'b01; mem[9'h01A][3][133:128] = {2'b10, 4'd3};
    fill(9'h033); mem[9'h033][0][133:132] = 2'b01; mem[9'h033][5][133:132] = 2'b10;
    fill(9'h044);
    fill(9'h050); mem[9'h050][0][133:132] = 2'b01; mem[9'h050][2][133:132] = 2'b10;
    fill(9'h060); fill(9'h061);
    fill(9'h070); mem[9'h070][0][133:132] = 2'b01; mem[9'h070][5][133:132] = 2'b10;
    fill(9'h071); mem[9'h071][0][133:132] = 2'b01; mem[9'h071][1][133:132] = 2'b10;

    repeat (3) tick();
    chk_reset_outputs("reset_state");
    i_rst = 1'b0;
    tick();

    // Single-line packet: timing pinned by hand.
    a0 = ack_n;
    send(9'h005, 48'h1111_2222_3333, 1);
    wait_ack(a0);
    chk("single_first_rd", first_rd_cyc - t0, 1);
    chk("single_rd_count", rd_n, 2);
    chk("single_wr_cycle", first_wr_cyc - t0, 4);
    chk("single_wr_count", wr_n, 1);
    chk("single_ack_cycle", ack_cyc - t0, 6);
    chk("single_release", last_rel, 9'h005);

    // Four-line packet.
    a0 = ack_n;
    send(9'h01A, 48'h0, 1);
    wait_ack(a0);
    chk("four_wr_count", wr_n, 4);
    chk("four_ack_count", ack_n - a0, 1);
    chk("four_release", last_rel, 9'h01A);
    chk("four_ack_cycle", ack_cyc - t0, 9);
    chk("four_tail_inv", last_dat[133:128], {2'b10, 4'd3});

    // Backpressure for five cycles mid-packet.
    a0 = ack_n;
    send(9'h033, 48'h0, 1);
    tick();
    i_tx_fifo_afull = 1'b1;
    repeat (5) tick();
    i_tx_fifo_afull = 1'b0;
    wait_ack(a0);
    chk("bp_wr_count", wr_n, 6);

    // Missing tail: eight lines, last forced to tail, error counter bumps.
    chk("err_before", ov_err_cnt, 16'd0);
    a0 = ack_n;
    send(9'h044, 48'h0, 1);
    wait_ack(a0);
    chk("notail_wr_count", wr_n, 8);
    chk("notail_forced", last_dat[133:128], {2'b10, 4'd0});
    chk("err_after", ov_err_cnt, 16'd1);

    // Protocol violations: new bufid in READ and in DONE are both ignored.
    a0 = ack_n;
    send(9'h050, 48'h0, 1);
    send(9'h060, 48'h0, 0);
    for (int i = 0; i < 100 && ov_prc_state != 2'd3; i++) tick();
    chk("reach_done", ov_prc_state, 2'd3);
    send(9'h061, 48'h0, 0);
    tick();
    tick();
    chk("violation_idle", ov_prc_state, 2'd0);
    chk("violation_acks", ack_n - a0, 1);
    chk("violation_release", last_rel, 9'h050);

    // Reset during READ, then a fresh packet.
    send(9'h070, 48'h0, 1);
    tick();
    tick();
    i_rst = 1'b1;
    exp_q.delete();
    rel_q.delete();
    err_model = 0;
    rd_active = 0;
    acc_n = ack_n;
    #1;
    chk_reset_outputs("reset_mid");
    tick();
    i_rst = 1'b0;
    wr_n = 0;
    repeat (4) tick();
    chk("no_post_reset_data", wr_n, 0);
    a0 = ack_n;
    send(9'h071, 48'hABCD_0123_4567, 1);
    wait_ack(a0);
    chk("post_reset_wr_count", wr_n, 2);
    chk("post_reset_release", last_rel, 9'h071);
`ifdef TSNTAG_RESTORE_EN
    chk("head_tag", head_dat[127:80], 48'hABCD_0123_4567);
`else
    chk("head_tag", head_dat[127:80], mem[9'h071][0][127:80]);
`endif

    chk("queue_empty", exp_q.size(), 0);
    chk("total_acks", ack_n, acc_n);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
